// File: rtl/ts_packet_gen_mc.sv
// Multi-channel MPEG-TS test packet generator: round-robin over NUM_CH PIDs, byte stream with valid/ready.
// Optional build macro TS_PRBS_PAYLOAD_EN selects PRBS-15 payload instead of the counter payload.
//
// state | meaning
// IDLE  | no packet in flight; select next enabled channel when i_enable is high
// SEND  | streaming bytes of the current packet, advancing only on transfer
// GAP   | inter-packet idle count-down; re-selects on the last gap cycle
module ts_packet_gen_mc #(
    parameter int          NUM_CH   = 4,
    parameter int          CH_W     = 2,
    parameter logic [12:0] PID_BASE = 13'h0100,
    parameter int          GAP_W    = 16
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_enable,
    input  logic [NUM_CH-1:0] i_ch_mask,
    input  logic              i_len_188_204n,
    input  logic [GAP_W-1:0]  i_gap,
    input  logic              i_ready,
    output logic [7:0]        o_ts_data,
    output logic              o_ts_valid,
    output logic              o_ts_start,
    output logic              o_ts_end,
    output logic [CH_W-1:0]   o_ts_ch,
    output logic [31:0]       o_pkt_count
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t            state;
    logic [7:0]        idx;
    logic              len204;
    logic [CH_W-1:0]   ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic [3:0]        cc [NUM_CH];

    logic              xfer;
    logic              last_byte;
    logic              pkt_done;
    logic              sel_window;
    logic              do_start;
    logic              sel_ok;
    logic [CH_W-1:0]   sel_base;
    logic [CH_W-1:0]   sel_ch;
    logic [7:0]        last_idx;
    logic [7:0]        nxt_idx;
    logic [7:0]        nxt_pld;
    logic [3:0]        cc_cur;

    function automatic logic [7:0] pkt_byte(input logic [7:0] bidx, input logic [CH_W-1:0] c,
                                            input logic [3:0] ccv, input logic [7:0] pld);
        logic [12:0] pid;
        logic [7:0]  b;
        pid = PID_BASE + 13'(c);
        case (bidx)
            8'd0:    b = 8'h47;
            8'd1:    b = {3'b010, pid[12:8]};
            8'd2:    b = pid[7:0];
            8'd3:    b = {4'b0001, ccv};
            default: b = (bidx < 8'd188) ? pld : 8'h00;
        endcase
        return b;
    endfunction

    assign xfer      = o_ts_valid & i_ready;
    assign last_idx  = len204 ? 8'd203 : 8'd187;
    assign last_byte = (idx == last_idx);
    assign pkt_done  = (state == SEND) && xfer && last_byte;
    assign nxt_idx   = idx + 8'd1;

    // At packet end the pointer moves to the current channel on the same edge,
    // so selection for a back-to-back packet must already search from it.
    assign sel_base   = (state == SEND) ? o_ts_ch : ptr;
    assign sel_window = (state == IDLE)
                     || ((state == GAP) && (gap_cnt <= GAP_W'(1)))
                     || (pkt_done && (i_gap == '0));
    assign do_start   = sel_window && i_enable && sel_ok;

    always_comb begin
        logic [NUM_CH-1:0] shifted;
        int                j;
        sel_ok  = 1'b0;
        sel_ch  = '0;
        shifted = '0;
        j       = 0;
        // Walk from farthest to nearest so the nearest set bit after the pointer wins.
        for (int k = NUM_CH; k >= 1; k--) begin
            j       = (int'(sel_base) + k) % NUM_CH;
            shifted = i_ch_mask >> j;
            if (shifted[0]) begin
                sel_ok = 1'b1;
                sel_ch = CH_W'(j);
            end
        end
    end

    always_comb begin
        cc_cur = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (o_ts_ch == CH_W'(c)) begin
                cc_cur = cc[c];
            end
        end
    end

`ifdef TS_PRBS_PAYLOAD_EN
    logic [14:0] lfsr;
    logic [14:0] lfsr_step;

    function automatic logic [14:0] prbs_step8(input logic [14:0] s);
        logic [14:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = {r[13:0], r[14] ^ r[13]};
        end
        return r;
    endfunction

    assign lfsr_step = prbs_step8(lfsr);
    // Byte 4 shows the current state; later payload bytes show the state after the advance that their predecessor's transfer causes.
    assign nxt_pld   = (nxt_idx == 8'd4) ? lfsr[7:0] : lfsr_step[7:0];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            lfsr <= 15'h7FFF;
        end else if ((state == SEND) && xfer && (idx >= 8'd4) && (idx <= 8'd187)) begin
            lfsr <= lfsr_step;
        end
    end
`else
    assign nxt_pld = nxt_idx - 8'd4;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            idx         <= '0;
            len204      <= 1'b0;
            ptr         <= CH_W'(NUM_CH - 1);
            gap_cnt     <= '0;
            o_ts_data   <= '0;
            o_ts_valid  <= 1'b0;
            o_ts_start  <= 1'b0;
            o_ts_end    <= 1'b0;
            o_ts_ch     <= '0;
            o_pkt_count <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cc[c] <= '0;
            end
        end else begin
            if (pkt_done) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (o_ts_ch == CH_W'(c)) begin
                        cc[c] <= cc[c] + 4'd1;
                    end
                end
                o_pkt_count <= o_pkt_count + 32'd1;
                ptr         <= o_ts_ch;
            end

            if (do_start) begin
                state      <= SEND;
                idx        <= '0;
                len204     <= ~i_len_188_204n;
                o_ts_ch    <= sel_ch;
                o_ts_data  <= 8'h47;
                o_ts_valid <= 1'b1;
                o_ts_start <= 1'b1;
                o_ts_end   <= 1'b0;
            end else if (pkt_done && (i_gap != '0)) begin
                state      <= GAP;
                gap_cnt    <= i_gap;
                o_ts_data  <= '0;
                o_ts_valid <= 1'b0;
                o_ts_start <= 1'b0;
                o_ts_end   <= 1'b0;
            end else if (sel_window) begin
                state      <= IDLE;
                o_ts_data  <= '0;
                o_ts_valid <= 1'b0;
                o_ts_start <= 1'b0;
                o_ts_end   <= 1'b0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end else if ((state == SEND) && xfer) begin
                idx        <= nxt_idx;
                o_ts_data  <= pkt_byte(nxt_idx, o_ts_ch, cc_cur, nxt_pld);
                o_ts_start <= 1'b0;
                o_ts_end   <= (nxt_idx == last_idx);
            end
        end
    end

endmodule
